sram_1r1w_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller that sits directly upstream of the 0rw1r1w SRAM macro (64b x 1024) and drives both of its ports.
- Exposes a valid/ready push interface and a valid/ready pop interface.
- Generates the macro's port-0 write strobes and port-1 read strobes.
- Captures the macro's one-cycle-latency, non-holding read data into a 2-entry output buffer so pop throughput is 1 word/cycle.

---
 rtl/sram_fifo_pkg.sv | 16 +
 rtl/sram_fifo_out_buf.sv | 49 ++++
 rtl/sram_1r1w_fifo_ctrl.sv | 95 +++++++++
 tb/tb_sram_1r1w_fifo_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the SRAM-backed FIFO controller.
// The SRAM macro is 64b x 1024, so these widths must track the macro.
package sram_fifo_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 10;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  // Level covers DEPTH words in the array plus the two buffered words.
  localparam int LVL_WIDTH  = ADDR_WIDTH + 2;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [LVL_WIDTH-1:0]  lvl_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/sram_fifo_out_buf.sv
// Two-entry capture buffer between the macro read port and the pop interface.
// The macro read data only holds for a moment after the edge, so each word is
// registered on the edge that ends its return cycle; the head is always a
// register output.
module sram_fifo_out_buf
  import sram_fifo_pkg::*;
(
  input  logic       clk0,
  input  logic       rst,
  input  logic       capture,
  input  word_t      cap_data,
  input  logic       pop,
  output word_t      head_data,
  output logic [1:0] occ
);

  word_t mem [2];
  logic  wr_idx;
  logic  rd_idx;
  logic  pop_ok;

  assign pop_ok    = pop && (occ != 2'd0);
  assign head_data = mem[rd_idx];

  // Capture/pop bookkeeping; capture and pop together leave occupancy unchanged.
  always_ff @(posedge clk0) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (capture) begin
        mem[wr_idx] <= cap_data;
        wr_idx      <= ~wr_idx;
      end
      if (pop_ok) begin
        rd_idx <= ~rd_idx;
      end
      case ({capture, pop_ok})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/sram_1r1w_fifo_ctrl.sv
// FIFO controller driving both ports of the 1R1W SRAM macro.
// Port 0 writes pushed words, port 1 prefetches into a 2-entry buffer so the
// pop side sustains one word per cycle despite the macro's read latency.
module sram_1r1w_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LVL_WIDTH-1:0]  level,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  cnt_t       sram_count;
  lvl_t       level_q;
  logic       inflight;
  logic       push;
  logic       pop_now;
  logic       rd_en;
  logic [1:0] buf_occ;
  logic [2:0] slots_used;

  sram_fifo_out_buf u_out_buf (
    .clk0      (clk0),
    .rst       (rst),
    .capture   (inflight),
    .cap_data  (sram_dout1),
    .pop       (pop_now),
    .head_data (out_data),
    .occ       (buf_occ)
  );

  assign in_ready  = !rst && (sram_count != cnt_t'(DEPTH));
  assign push      = in_valid && in_ready;
  assign out_valid = !rst && (buf_occ != 2'd0);
  assign pop_now   = out_valid && out_ready;
  assign level     = rst ? '0 : level_q;

  // Buffer slots already claimed once this cycle's pop is taken out.
  assign slots_used = {1'b0, buf_occ} + {2'b00, inflight} - {2'b00, pop_now};

  // sram_count only includes words pushed in earlier cycles. Those were
  // written at the negedge of their push cycle, before any read launched now
  // is sampled by the macro, so the whole count is readable. The word being
  // pushed this cycle is excluded, so a read never hits the write address.
  assign rd_en = !rst && (sram_count != '0) && (slots_used < 3'd2);

  assign sram_csb0  = !push;
  assign sram_addr0 = push ? wr_ptr : '0;
  assign sram_din0  = push ? in_data : '0;
  assign sram_csb1  = !rd_en;
  assign sram_addr1 = rd_en ? rd_ptr : '0;

  // Pointers, array occupancy, read-in-flight flag and level.
  always_ff @(posedge clk0) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sram_count <= '0;
      inflight   <= 1'b0;
      level_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      case ({push, rd_en})
        2'b10:   sram_count <= sram_count + cnt_t'(1);
        2'b01:   sram_count <= sram_count - cnt_t'(1);
        default: sram_count <= sram_count;
      endcase
      inflight <= rd_en;
      case ({push, pop_now})
        2'b10:   level_q <= level_q + lvl_t'(1);
        2'b01:   level_q <= level_q - lvl_t'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_1r1w_fifo_ctrl.sv
// Bench for sram_1r1w_fifo_ctrl with a behavioural model of the 1R1W macro.
// Inputs change 1 time unit after posedge; the monitor samples at negedge.
module tb_sram_1r1w_fifo_ctrl;
  import sram_fifo_pkg::*;

  localparam logic [63:0] GARBAGE = 64'hBADD_A7A0_DEAD_BEEF;

  logic                  clk0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [LVL_WIDTH-1:0]  level;
  logic                  sram_csb0;
  logic [ADDR_WIDTH-1:0] sram_addr0;
  logic [DATA_WIDTH-1:0] sram_din0;
  logic                  sram_csb1;
  logic [ADDR_WIDTH-1:0] sram_addr1;
  logic [DATA_WIDTH-1:0] sram_dout1;

  sram_1r1w_fifo_ctrl dut (
    .clk0       (clk0),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  initial begin
    clk0 = 1'b0;
    forever #5 clk0 = ~clk0;
  end

  // ---------------- macro model ----------------
  logic [63:0]           mem [DEPTH];
  logic                  w_pend;
  logic                  r_pend;
  logic [ADDR_WIDTH-1:0] w_a;
  logic [ADDR_WIDTH-1:0] r_a;
  logic [63:0]           w_d;

  initial sram_dout1 = GARBAGE;

  always @(posedge clk0) begin
    w_pend <= !sram_csb0;
    w_a    <= sram_addr0;
    w_d    <= sram_din0;
    r_pend <= !sram_csb1;
    r_a    <= sram_addr1;
  end

  always @(negedge clk0) begin
    if (w_pend === 1'b1) mem[w_a] = w_d;
    if (r_pend === 1'b1) sram_dout1 = mem[r_a];
  end

  always begin
    @(posedge clk0);
    #1;
    sram_dout1 = GARBAGE;
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  logic [63:0]           exp_q [$];
  logic [ADDR_WIDTH-1:0] wr_m;
  logic [ADDR_WIDTH-1:0] rd_m;
  int sram_m = 0;
  int lvl_m = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_wraps = 0;
  int rd_wraps = 0;
  logic strm_mark;
  int strm_push_cyc = -1;
  int strm_first_pop = -1;
  int strm_last_pop = -1;
  int strm_pops = 0;

  initial begin
    wr_m = '0;
    rd_m = '0;
    strm_mark = 1'b0;
  end

  always @(negedge clk0) begin
    logic [63:0] e;
    cyc++;
    if (rst) begin
      chk("rst_level", 64'(level), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_csb0", 64'(sram_csb0), 64'd1);
      chk("rst_csb1", 64'(sram_csb1), 64'd1);
      exp_q.delete();
      wr_m   = '0;
      rd_m   = '0;
      sram_m = 0;
      lvl_m  = 0;
    end else begin
      chk("level", 64'(level), 64'(lvl_m));
      chk("in_ready", 64'(in_ready), 64'(sram_m < DEPTH));
      chk("csb0", 64'(sram_csb0), 64'(!(in_valid && in_ready)));
      if (!sram_csb0 && !sram_csb1)
        chk("rw_collide", 64'(sram_addr0 != sram_addr1), 64'd1);
      if (!sram_csb1) begin
        chk("rd_nonempty", 64'(sram_m > 0), 64'd1);
        chk("addr1", 64'(sram_addr1), 64'(rd_m));
        if (rd_m == 10'h3FF) rd_wraps++;
        rd_m = rd_m + 10'd1;
        rd_cnt++;
        sram_m--;
      end
      if (in_valid && in_ready) begin
        chk("addr0", 64'(sram_addr0), 64'(wr_m));
        chk("din0", sram_din0, in_data);
        exp_q.push_back(in_data);
        if (wr_m == 10'h3FF) wr_wraps++;
        wr_m = wr_m + 10'd1;
        sram_m++;
        lvl_m++;
        if (strm_mark && strm_push_cyc < 0) strm_push_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_data, GARBAGE);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
        end
        lvl_m--;
        if (strm_mark) begin
          if (strm_first_pop < 0) strm_first_pop = cyc;
          strm_last_pop = cyc;
          strm_pops++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size() == 0 && !out_valid), 64'd1);
    chk({name, "_level"}, 64'(level), 64'd0);
  endtask

  initial begin
    int k;
    int sent;
    int snap;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_level", 64'(level), 64'd0);
    chk("post_rst_csb1", 64'(sram_csb1), 64'd1);

    // single word latency
    repeat (4) tick();
    in_valid = 1'b1;
    in_data = 64'h0123_4567_89AB_CDEF;
    out_ready = 1'b1;
    #1;
    chk("lat_csb0", 64'(sram_csb0), 64'd0);
    chk("lat_addr0", 64'(sram_addr0), 64'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("lat_csb1", 64'(sram_csb1), 64'd0);
    chk("lat_addr1", 64'(sram_addr1), 64'd0);
    tick();
    chk("lat_t2_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lat_t3_valid", 64'(out_valid), 64'd1);
    chk("lat_t3_data", out_data, 64'h0123_4567_89AB_CDEF);
    tick();
    chk("lat_level0", 64'(level), 64'd0);

    // streaming 0..99
    strm_mark = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data = 64'(i);
      tick();
    end
    drain(200, "stream_drain");
    strm_mark = 1'b0;
    chk("stream_fill", 64'(strm_first_pop - strm_push_cyc), 64'd3);
    chk("stream_rate", 64'(strm_last_pop - strm_first_pop), 64'd99);
    chk("stream_pops", 64'(strm_pops), 64'd100);

    // fill to full with out_ready low
    out_ready = 1'b0;
    snap = rd_cnt;
    k = 0;
    for (int i = 0; i < 1200; i++) begin
      in_valid = 1'b1;
      in_data = {32'hF00D_0000, 32'(k)};
      #1;
      if (!in_ready) break;
      k++;
      tick();
    end
    in_valid = 1'b0;
    chk("full_accepted", 64'(k), 64'd1026);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_level", 64'(level), 64'd1026);
    repeat (4) tick();
    chk("full_reads", 64'(rd_cnt - snap), 64'd2);
    chk("full_hold_csb1", 64'(sram_csb1), 64'd1);
    drain(1200, "full_drain");

    // long run across pointer wrap with random back-pressure
    sent = 0;
    for (int i = 0; i < 20000 && sent < 3000; i++) begin
      in_valid = 1'b1;
      in_data = {32'hA5A5_0000 + 32'(sent), ~32'(sent)};
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) sent++;
      tick();
    end
    chk("wrap_sent", 64'(sent), 64'd3000);
    drain(4000, "wrap_drain");
    chk("wr_wraps", 64'(wr_wraps), 64'd4);
    chk("rd_wraps", 64'(rd_wraps), 64'd4);

    // reset with a read in flight
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = 64'h5E5E_0000_0000_0000 + 64'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    out_ready = 1'b1;
    #1;
    chk("rst_pop_issues_read", 64'(sram_csb1), 64'd0);
    tick();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_out_valid", 64'(out_valid), 64'd0);
    chk("after_rst_level", 64'(level), 64'd0);
    chk("after_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("after_rst_no_output", 64'(out_valid), 64'd0);

    // pop on empty, then push+pop at level 1
    tick();
    chk("empty_pop_level", 64'(level), 64'd0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 64'hC0FF_EE00_1234_5678;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("solo_valid", 64'(out_valid), 64'd1);
    chk("solo_level", 64'(level), 64'd1);
    in_valid = 1'b1;
    in_data = 64'h7777_8888_9999_AAAA;
    out_ready = 1'b1;
    #1;
    chk("simul_handshake", 64'(in_ready && out_valid), 64'd1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("simul_level", 64'(level), 64'd1);
    drain(20, "final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    n_miss++;
    $display("FAIL global_timeout: got time %0t, wanted finish before it", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
